// File: rtl/csr_pkg.sv
// ----------------------------------------------------------------------------
// csr_pkg
// Shared types and constants for the CSR access path.
//   csr_write_func   : funct3[1:0] write operation (RW / RS / RC, 00 = none)
//   csr_input_sel    : funct3[2] operand select (register value or zimm)
//   csr_funct3_t     : {input_select, write_func}
//   csr_addr_t       : {access[11:10], priv[9:8], addr[7:0]}
//   csr_acc_state_t  : sequencing states of csr_access_unit
//   EXC_ILLEGAL_INSTR: mcause code for illegal-instruction
// Helper functions decode the read/write enables and the static checks.
// ----------------------------------------------------------------------------
package csr_pkg;

    localparam int CSR_XLEN          = 32;
    localparam int EXC_ILLEGAL_INSTR = 2;

    // Top two address bits equal to 11 mark a read-only CSR.
    localparam logic [1:0] CSR_ACCESS_RO = 2'b11;

    typedef enum logic [1:0] {
        CSR_WF_NONE = 2'b00,
        CSR_WF_RW   = 2'b01,
        CSR_WF_RS   = 2'b10,
        CSR_WF_RC   = 2'b11
    } csr_write_func;

    typedef enum logic {
        CSR_SEL_REG = 1'b0,
        CSR_SEL_IMM = 1'b1
    } csr_input_sel;

    typedef struct packed {
        csr_input_sel  input_select;
        csr_write_func write_func;
    } csr_funct3_t;

    typedef struct packed {
        logic [1:0] access;
        logic [1:0] priv;
        logic [7:0] addr;
    } csr_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } csr_acc_state_t;

    // CSRRW with rd==x0 must not read (no side effects of the read);
    // set/clear always read.
    function automatic logic csr_read_enable(input csr_write_func func,
                                             input logic [4:0]    rd_idx);
        return (func == CSR_WF_RW) ? (rd_idx != 5'd0) : 1'b1;
    endfunction

    // Set/clear with rs1==x0 (or zimm==0) are pure reads.
    function automatic logic csr_write_enable(input csr_write_func func,
                                              input logic [4:0]    rs1_idx);
        return (func == CSR_WF_RW) ? 1'b1 : (rs1_idx != 5'd0);
    endfunction

    // Checks that need nothing from the CSR file and can be decided at accept.
    function automatic logic csr_static_illegal(input csr_write_func func,
                                                input logic          write_en,
                                                input logic [1:0]    access,
                                                input logic [1:0]    csr_priv,
                                                input logic [1:0]    hart_priv);
        return (func == CSR_WF_NONE)
            || (hart_priv < csr_priv)
            || ((access == CSR_ACCESS_RO) && write_en);
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// ----------------------------------------------------------------------------
// csr_rmw_alu
// Combinational read-modify-write: computes the new CSR value.
//   write_func_i : RW / RS / RC
//   old_i        : value read from the CSR file (unused for RW)
//   operand_i    : rs1 value or zero-extended zimm
//   new_o        : value to write back
// ----------------------------------------------------------------------------
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int XLEN = CSR_XLEN
) (
    input  csr_write_func    write_func_i,
    input  logic [XLEN-1:0]  old_i,
    input  logic [XLEN-1:0]  operand_i,
    output logic [XLEN-1:0]  new_o
);

    always_comb begin
        new_o = '0;
        unique case (write_func_i)
            CSR_WF_RW: new_o = operand_i;
            CSR_WF_RS: new_o = old_i | operand_i;
            CSR_WF_RC: new_o = old_i & ~operand_i;
            default:   new_o = '0;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// ----------------------------------------------------------------------------
// csr_access_unit
// Sequences one decoded CSRRW/RS/RC[I] instruction at a time between decode
// and the CSR register file: static legality checks, CSR read, CSR write,
// then a result (old value) or illegal-instruction exception to writeback.
//
// Ports
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   in_*                 : decoded instruction from decode (valid/ready)
//   csr_addr_o           : CSR file address, stable from READ through WRITE
//   csr_rd_en_o          : 1-cycle read strobe (READ state)
//   csr_rdata_i          : read data, same cycle as csr_rd_en_o
//   csr_rd_illegal_i     : address unimplemented, sampled with csr_rd_en_o
//   csr_wr_en_o          : 1-cycle write strobe (WRITE state)
//   csr_wdata_o          : new CSR value
//   wb_*                 : result to writeback (valid/ready)
//   instr_retired_o      : 1-cycle pulse after a non-exception wb handshake
//   dbg_state_o          : current sequencing state
//
// Handshakes (both in_* and wb_*): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until that edge; ready may be high without valid.
//
// All strobes and wb_* outputs decode registered state only; in_ready_o is
// the single output with no register stage beyond state_q.
// ----------------------------------------------------------------------------
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int XLEN        = CSR_XLEN,
    parameter int EXC_ILLEGAL = EXC_ILLEGAL_INSTR
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_funct3_i,
    input  logic [11:0]       in_csr_addr_i,
    input  logic [4:0]        in_rs1_idx_i,
    input  logic [XLEN-1:0]   in_rs1_value_i,
    input  logic [4:0]        in_rd_idx_i,
    input  logic [1:0]        in_priv_mode_i,

    output logic [11:0]       csr_addr_o,
    output logic              csr_rd_en_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    input  logic              csr_rd_illegal_i,
    output logic              csr_wr_en_o,
    output logic [XLEN-1:0]   csr_wdata_o,

    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [4:0]        wb_rd_idx_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              wb_exc_o,
    output logic [XLEN-1:0]   wb_exc_cause_o,
    output logic              instr_retired_o,

    output csr_acc_state_t    dbg_state_o
);

    // ------------------------------------------------------------------
    // Decode of the presented instruction (only used on accept)
    // ------------------------------------------------------------------
    csr_funct3_t       in_f3;
    csr_addr_t         in_addr;
    logic [XLEN-1:0]   in_operand;
    logic              in_re;
    logic              in_we;
    logic              in_illegal;

    assign in_f3   = in_funct3_i;
    assign in_addr = in_csr_addr_i;

    assign in_operand = (in_f3.input_select == CSR_SEL_IMM)
                      ? {{(XLEN-5){1'b0}}, in_rs1_idx_i}
                      : in_rs1_value_i;

    assign in_re      = csr_read_enable(in_f3.write_func, in_rd_idx_i);
    assign in_we      = csr_write_enable(in_f3.write_func, in_rs1_idx_i);
    assign in_illegal = csr_static_illegal(in_f3.write_func, in_we,
                                           in_addr.access, in_addr.priv,
                                           in_priv_mode_i);

    // ------------------------------------------------------------------
    // State and latched instruction
    // ------------------------------------------------------------------
    csr_acc_state_t    state_q,   state_d;
    csr_write_func     func_q,    func_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    csr_addr_t         addr_q,    addr_d;
    logic [4:0]        rd_q,      rd_d;
    logic              re_q,      re_d;
    logic              we_q,      we_d;
    logic [XLEN-1:0]   old_q,     old_d;
    logic              exc_q,     exc_d;
    logic              retired_q, retired_d;

    logic [XLEN-1:0]   new_value;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            func_q    <= CSR_WF_NONE;
            operand_q <= '0;
            addr_q    <= '0;
            rd_q      <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            old_q     <= '0;
            exc_q     <= 1'b0;
            retired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            operand_q <= operand_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            re_q      <= re_d;
            we_q      <= we_d;
            old_q     <= old_d;
            exc_q     <= exc_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        operand_d = operand_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        re_d      = re_q;
        we_d      = we_q;
        old_d     = old_q;
        exc_d     = exc_q;
        retired_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    func_d    = in_f3.write_func;
                    operand_d = in_operand;
                    addr_d    = in_addr;
                    rd_d      = in_rd_idx_i;
                    re_d      = in_re;
                    we_d      = in_we;
                    old_d     = '0;
                    exc_d     = in_illegal;
                    if (in_illegal) begin
                        state_d = RESP;
                    end else if (in_re) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            READ: begin
                old_d = csr_rdata_i;
                // An unimplemented address aborts before any write is issued.
                if (csr_rd_illegal_i) begin
                    exc_d   = 1'b1;
                    state_d = RESP;
                end else if (we_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                end
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (wb_ready_i) begin
                    state_d   = IDLE;
                    retired_d = !exc_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    csr_rmw_alu #(
        .XLEN (XLEN)
    ) u_rmw_alu (
        .write_func_i (func_q),
        .old_i        (old_q),
        .operand_i    (operand_q),
        .new_o        (new_value)
    );

    // ------------------------------------------------------------------
    // Outputs, all decoded from registered state
    // ------------------------------------------------------------------
    assign in_ready_o      = (state_q == IDLE);

    assign csr_addr_o      = addr_q;
    assign csr_rd_en_o     = (state_q == READ);
    assign csr_wr_en_o     = (state_q == WRITE);
    assign csr_wdata_o     = (state_q == WRITE) ? new_value : '0;

    assign wb_valid_o      = (state_q == RESP);
    assign wb_exc_o        = (state_q == RESP) && exc_q;
    assign wb_rd_idx_o     = ((state_q == RESP) && !exc_q) ? rd_q : 5'd0;
    // Old value is only reported when the CSR was actually read.
    assign wb_data_o       = ((state_q == RESP) && !exc_q && re_q) ? old_q : '0;
    assign wb_exc_cause_o  = wb_exc_o ? XLEN'(EXC_ILLEGAL) : '0;
    assign instr_retired_o = retired_q;

    assign dbg_state_o     = state_q;

endmodule
